// File: rtl/avalon_spi_csr.sv
// Avalon-MM CSR front end for an SPI engine: TX/RX FIFOs, status/control, completion sync.
// Every access takes one wait state; go_transfer and data_write_to_spi are registered off the LOAD state.
module avalon_spi_csr #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chip_select,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    output logic [DATA_W-1:0] read_data,
    output logic              wait_request,
    output logic              go_transfer,
    output logic [DATA_W-1:0] data_write_to_spi,
    input  logic              data_pack_ready,
    input  logic [DATA_W-1:0] data_read_from_spi,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_CAPTURE} state_t;

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
    logic [2:0]        sync_q;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] spi_dat_q, spi_dat_d;
    logic              go_q, go_d;
    logic              irq_q, irq_d;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic pending, commit, wr_commit, rd_commit;
    logic sel_tx, sel_rx, sel_stat, sel_ctrl, sel_clr;
    logic enable, irq_en, dummy_tx;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_req, tx_push, tx_pop, tx_ovf_evt;
    logic rx_push_req, rx_push, rx_pop, rx_ovr_evt;
    logic flags_clr, done;
    logic [31:0] status, rd_word;

    assign pending      = chip_select & (read | write);
    assign wait_request = pending & ~ack_q;
    assign commit       = pending & ack_q;
    assign wr_commit    = commit & write;
    assign rd_commit    = commit & read;

    assign sel_tx   = (address == ADDR_W'(0));
    assign sel_rx   = (address == ADDR_W'(1));
    assign sel_stat = (address == ADDR_W'(2));
    assign sel_ctrl = (address == ADDR_W'(3));
    assign sel_clr  = (address == ADDR_W'(4));

    assign enable   = ctrl_q[0];
    assign irq_en   = ctrl_q[1];
    assign dummy_tx = ctrl_q[2];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_W'(FIFO_DEPTH));

    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign tx_pop      = (state_q == ST_LOAD) & ~tx_empty;
    assign tx_push_req = wr_commit & sel_tx;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf_evt  = tx_push_req & tx_full & ~tx_pop;

    assign rx_pop      = rd_commit & sel_rx & ~rx_empty;
    assign rx_push_req = (state_q == ST_CAPTURE);
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_evt  = rx_push_req & rx_full & ~rx_pop;

    assign flags_clr = wr_commit & sel_clr;
    // sync_q[1] is the synchronised level, sync_q[2] its previous value.
    assign done      = sync_q[2] & ~sync_q[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable && (!tx_empty || dummy_tx)) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_WAIT;
            ST_WAIT:    if (done) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_d     = pending & ~ack_q;
        ctrl_d    = ctrl_q;
        if (wr_commit && sel_ctrl) ctrl_d = write_data[2:0];
        tx_ovf_d  = (tx_ovf_q & ~(flags_clr & write_data[5])) | tx_ovf_evt;
        rx_ovr_d  = (rx_ovr_q & ~(flags_clr & write_data[6])) | rx_ovr_evt;
        spi_dat_d = spi_dat_q;
        if (state_q == ST_LOAD) spi_dat_d = tx_empty ? '0 : tx_mem[tx_rptr_q];
        go_d      = (state_q == ST_LOAD);
        irq_d     = irq_en & (~rx_empty | tx_ovf_q | rx_ovr_q);

        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_W'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_W'(1);
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_W'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end

    always_comb begin
        status       = '0;
        status[0]    = tx_empty;
        status[1]    = tx_full;
        status[2]    = rx_empty;
        status[3]    = rx_full;
        status[4]    = (state_q != ST_IDLE);
        status[5]    = tx_ovf_q;
        status[6]    = rx_ovr_q;
        status[15:8] = 8'(rx_cnt_q);
        rd_word      = '0;
        if (sel_rx && !rx_empty) rd_word[DATA_W-1:0] = rx_mem[rx_rptr_q];
        else if (sel_stat)       rd_word = status;
        else if (sel_ctrl)       rd_word[2:0] = ctrl_q;
        read_data_d = rd_commit ? rd_word[DATA_W-1:0] : read_data_q;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= write_data;
        if (rx_push) rx_mem[rx_wptr_q] <= data_read_from_spi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            ctrl_q      <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            sync_q      <= 3'b111;
            read_data_q <= '0;
            spi_dat_q   <= '0;
            go_q        <= 1'b0;
            irq_q       <= 1'b0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            ctrl_q      <= ctrl_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovr_q    <= rx_ovr_d;
            sync_q      <= {sync_q[1:0], data_pack_ready};
            read_data_q <= read_data_d;
            spi_dat_q   <= spi_dat_d;
            go_q        <= go_d;
            irq_q       <= irq_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
        end
    end

    assign read_data         = read_data_q;
    assign data_write_to_spi = spi_dat_q;
    assign go_transfer       = go_q;
    assign irq               = irq_q;
endmodule

// File: tb/tb_avalon_spi_csr.sv
// Scoreboard bench: TX words queued on write and checked at go_transfer, RX words queued on completion and checked on read.
module tb_avalon_spi_csr;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        chip_select, write, read;
    logic [2:0]  address;
    logic [31:0] write_data, read_data, data_write_to_spi, data_read_from_spi;
    logic        wait_request, go_transfer, data_pack_ready, irq;

    int errors = 0;
    int checks = 0;
    int n_go = 0;
    int n_served = 0;
    int model_tx_cnt = 0;
    int rx_model_cnt = 0;
    bit dummy_mode = 1'b0;
    logic [31:0] exp_tx[$];
    logic [31:0] exp_rx[$];

    avalon_spi_csr dut (
        .clk(clk), .reset_n(reset_n), .chip_select(chip_select), .address(address),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .wait_request(wait_request), .go_transfer(go_transfer),
        .data_write_to_spi(data_write_to_spi), .data_pack_ready(data_pack_ready),
        .data_read_from_spi(data_read_from_spi), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no finish required=finish");
        $fatal(1);
    end

    // TX side of the scoreboard: every go_transfer must carry the next queued word.
    always @(negedge clk) begin
        if (reset_n && go_transfer) begin
            logic [31:0] e;
            bit known;
            n_go++;
            known = 1'b1;
            e = 32'd0;
            if (exp_tx.size() > 0) begin
                e = exp_tx.pop_front();
                model_tx_cnt--;
            end else if (!dummy_mode) begin
                known = 1'b0;
            end
            checks++;
            if (!known) begin
                errors++;
                $display("FAIL go_unexpected got=go_transfer data=%h required=no transfer", data_write_to_spi);
            end else if (data_write_to_spi !== e) begin
                errors++;
                $display("FAIL go_data got=%h required=%h", data_write_to_spi, e);
            end
        end
    end

    task automatic bus_access(input logic is_wr, input logic [2:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd);
        int waits = 0;
        @(posedge clk); #1;
        chip_select = 1'b1; address = addr; write = is_wr; read = ~is_wr; write_data = wd;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wait_request) waits++;
            else break;
        end
        @(posedge clk); #1;
        chip_select = 1'b0; write = 1'b0; read = 1'b0;
        rd = read_data;
        checks++;
        if (waits != 1) begin
            errors++;
            $display("FAIL wait_states addr=%0d got=%0d required=1", addr, waits);
        end
    endtask

    task automatic wr_tx(input logic [31:0] d);
        logic [31:0] rd;
        if (model_tx_cnt < 4) begin
            exp_tx.push_back(d);
            model_tx_cnt++;
        end
        bus_access(1'b1, 3'd0, d, rd);
    endtask

    task automatic spi_serve(input logic [31:0] w);
        int t = 0;
        while (n_go <= n_served && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_go <= n_served) begin
            checks++; errors++;
            $display("FAIL spi_go_timeout got=none required=go_transfer");
        end else begin
            n_served++;
            data_read_from_spi = w;
            data_pack_ready = 1'b0;
            if (rx_model_cnt < 4) begin
                exp_rx.push_back(w);
                rx_model_cnt++;
            end
            repeat (5) @(negedge clk);
            data_pack_ready = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic drain_rx(input int n);
        logic [31:0] rd, e;
        for (int i = 0; i < n; i++) begin
            bus_access(1'b0, 3'd1, 32'd0, rd);
            e = 32'd0;
            if (exp_rx.size() > 0) begin
                e = exp_rx.pop_front();
                rx_model_cnt--;
            end
            checks++;
            if (rd !== e) begin
                errors++;
                $display("FAIL rxdata[%0d] got=%h required=%h", i, rd, e);
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0; chip_select = 1'b0; write = 1'b0; read = 1'b0; address = 3'd0;
        write_data = 32'd0; data_pack_ready = 1'b1; data_read_from_spi = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL rst_read_data got=%h required=0", read_data); end
        checks++; if (go_transfer !== 1'b0) begin errors++; $display("FAIL rst_go got=%b required=0", go_transfer); end
        checks++; if (data_write_to_spi !== 32'd0) begin errors++; $display("FAIL rst_spi_data got=%h required=0", data_write_to_spi); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b required=0", irq); end
        checks++; if (wait_request !== 1'b0) begin errors++; $display("FAIL rst_wait got=%b required=0", wait_request); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL rst_status got=%h required=05", rd); end
        bus_access(1'b0, 3'd3, 32'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_control got=%h required=0", rd); end
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        wr_tx(32'hA5A5_0001);
        bus_access(1'b0, 3'd0, 32'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL txdata_read got=%h required=0", rd); end
        bus_access(1'b1, 3'd3, 32'd1, rd);
        spi_serve(32'h1234_5678);
        drain_rx(1);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL basic_status got=%h required=05", rd); end
        bus_access(1'b1, 3'd3, 32'd0, rd);
    endtask

    task automatic test_tx_overflow;
        logic [31:0] rd;
        int base;
        for (int i = 0; i < 5; i++) wr_tx(32'h1000_0000 + i);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h26) begin errors++; $display("FAIL ovf_status got=%h required=26", rd); end
        bus_access(1'b1, 3'd4, 32'h20, rd);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h06) begin errors++; $display("FAIL ovf_clr_status got=%h required=06", rd); end
        base = n_go;
        bus_access(1'b1, 3'd3, 32'd1, rd);
        for (int i = 0; i < 4; i++) spi_serve(32'h2000_0000 + i);
        repeat (20) @(negedge clk);
        checks++; if (n_go - base != 4) begin errors++; $display("FAIL ovf_xfer_count got=%0d required=4", n_go - base); end
        bus_access(1'b1, 3'd3, 32'd0, rd);
        drain_rx(4);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        @(posedge clk); #1;
        chip_select = 1'b0; write = 1'b1; address = 3'd0; write_data = 32'h5555_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (wait_request !== 1'b0) begin errors++; $display("FAIL cs_low_wait[%0d] got=%b required=0", i, wait_request); end
        end
        @(posedge clk); #1;
        write = 1'b0;
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL cs_low_status got=%h required=05", rd); end
        @(posedge clk); #1;
        chip_select = 1'b1; write = 1'b1; address = 3'd0; write_data = 32'hBEEF_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (wait_request !== ((i % 2) == 0)) begin
                errors++; $display("FAIL held_wait[%0d] got=%b required=%b", i, wait_request, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                write_data = 32'hBEEF_0000 + i;
                exp_tx.push_back(32'hBEEF_0000 + i);
                model_tx_cnt++;
            end
            @(posedge clk);
        end
        #1;
        chip_select = 1'b0; write = 1'b0;
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h06) begin errors++; $display("FAIL held_status got=%h required=06", rd); end
        bus_access(1'b1, 3'd3, 32'd1, rd);
        for (int i = 0; i < 4; i++) spi_serve(32'h3000_0000 + i);
        bus_access(1'b1, 3'd3, 32'd0, rd);
        drain_rx(4);
    endtask

    task automatic test_dummy_rx_overrun;
        logic [31:0] rd;
        dummy_mode = 1'b1;
        bus_access(1'b1, 3'd3, 32'd5, rd);
        for (int i = 0; i < 5; i++) spi_serve(32'h0000_0100 + i);
        bus_access(1'b1, 3'd3, 32'd0, rd);
        while (n_go > n_served) spi_serve(32'hDEAD_0000);
        repeat (20) @(negedge clk);
        checks++; if (n_go != n_served) begin errors++; $display("FAIL dummy_stop got=%0d extra required=0", n_go - n_served); end
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h449) begin errors++; $display("FAIL ovr_status got=%h required=449", rd); end
        bus_access(1'b1, 3'd4, 32'h40, rd);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h409) begin errors++; $display("FAIL ovr_clr_status got=%h required=409", rd); end
        drain_rx(5);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL drained_status got=%h required=05", rd); end
        dummy_mode = 1'b0;
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        int t = 0;
        wr_tx(32'hCAFE_0003);
        bus_access(1'b1, 3'd3, 32'd3, rd);
        while (n_go <= n_served && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (n_go <= n_served) begin
            errors++; $display("FAIL irq_go_timeout got=none required=go_transfer");
        end else begin
            n_served++;
            data_read_from_spi = 32'h0BAD_F00D;
            data_pack_ready = 1'b0;
            exp_rx.push_back(32'h0BAD_F00D);
            rx_model_cnt++;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k == 4) begin checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b required=0", irq); end end
                if (k == 5) begin checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b required=1", irq); end end
            end
            data_pack_ready = 1'b1;
            repeat (3) @(negedge clk);
        end
        drain_rx(1);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b required=1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got=%b required=0", irq); end
        drain_rx(1);
        bus_access(1'b1, 3'd3, 32'd0, rd);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        int t = 0;
        int go_before;
        bus_access(1'b1, 3'd3, 32'd1, rd);
        wr_tx(32'h0000_0077);
        while (n_go <= n_served && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (n_go <= n_served) begin errors++; $display("FAIL mid_go_timeout got=none required=go_transfer"); end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (data_write_to_spi !== 32'd0) begin errors++; $display("FAIL mid_rst_spi_data got=%h required=0", data_write_to_spi); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL mid_rst_read_data got=%h required=0", read_data); end
        checks++; if (go_transfer !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL mid_rst_go_irq got=%b%b required=00", go_transfer, irq); end
        exp_tx.delete(); exp_rx.delete();
        model_tx_cnt = 0; rx_model_cnt = 0; n_served = n_go;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        go_before = n_go;
        @(negedge clk);
        data_read_from_spi = 32'hFFFF_0000;
        data_pack_ready = 1'b0;
        repeat (5) @(negedge clk);
        data_pack_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus_access(1'b0, 3'd2, 32'd0, rd);
        checks++; if (rd !== 32'h05) begin errors++; $display("FAIL mid_status got=%h required=05", rd); end
        checks++; if (n_go != go_before) begin errors++; $display("FAIL mid_no_go got=%0d required=%0d", n_go, go_before); end
        drain_rx(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tx_overflow();
        test_back_to_back();
        test_dummy_rx_overrun();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
